pwm_update_ctrl: RTL
====================

PWM_UPDATE_CTRL -- requirements
Module: pwm_update_ctrl

Interface
- REQ-001: Parameter CMP_W, default 18, width of the PWM compare value.
- REQ-002: Parameter STEP_W, default 8, width of the per-period slew step register.
- REQ-003: clk  input  1  single system clock; all state on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: wr_en  input  1  one-cycle byte-write strobe from the I2C slave.
- REQ-006: wr_addr  input  3  register address for the write.
- REQ-007: wr_data  input  8  write data byte.
- REQ-008: rd_addr  input  3  register address for read-back.
- REQ-009: rd_data  output  8  registered read data, valid 1 cycle after rd_addr.
- REQ-010: period_end  input  1  one-cycle pulse from the PWM counter at period wrap.
- REQ-011: cmp_out  output  CMP_W  active compare value driven to the PWM datapath.
- REQ-012: upd_pulse  output  1  high for exactly the cycle after cmp_out changes.
- REQ-013: busy  output  1  high while a committed target is not yet reached (state ARMED or RAMP).

Function
- REQ-014: Register map shall be: 0 staged[7:0]; 1 staged[15:8]; 2 staged[17:16] in bits 1:0, bits 7:2 ignored and read 0; 3 COMMIT (write of any value commits, reads 0); 4 STEP; 5 STATUS (bit0 busy, bit1 = state ARMED, others 0); 6-7 read 0, writes ignored.
- REQ-015: Writes to 0-2 and 4 shall update only the staging or STEP register and never change cmp_out directly.
- REQ-016: A COMMIT write shall copy the staged value into target in that cycle.
- REQ-017: FSM states shall be IDLE, ARMED and RAMP.
- REQ-018: On COMMIT, the next state shall be IDLE if the new target equals cmp_out, else ARMED.
- REQ-019: In ARMED or RAMP, each period_end shall apply one move; cmp_out shall never change except on a period_end cycle.
- REQ-020: When STEP = 0, a move shall set cmp_out to target.
- REQ-021: When STEP != 0, a move shall add or subtract min(STEP, |target - cmp_out|).
- REQ-022: The difference shall be computed at CMP_W+1 bits; cmp_out shall never overshoot the target and never wrap.
- REQ-023: After a move, the state shall be IDLE if cmp_out equals target, else RAMP.
- REQ-024: A COMMIT in ARMED or RAMP shall replace target and continue from the current cmp_out; if the new target equals cmp_out, the state shall go to IDLE without a move.
- REQ-025: COMMIT and period_end in the same cycle shall apply the move toward the newly committed target.
- REQ-026: A STEP write mid-ramp shall take effect on the next period_end.
- REQ-027: period_end in IDLE shall be ignored.

Reset
- REQ-028: When rst_n is low: cmp_out = 0, staged = 0, target = 0, STEP = 0, state = IDLE, rd_data = 0, upd_pulse = 0, busy = 0.
- REQ-029: Reset asserted mid-ramp shall abort immediately with no further upd_pulse.
- REQ-030: After rst_n deasserts, the block shall accept writes on the first clock edge.

Verification
- REQ-031: STEP=0; write 0x44, 0x13, 0x00 to regs 0-2, then COMMIT -> cmp_out stays 0 and busy=1 until the next period_end, then cmp_out=0x01344 with one upd_pulse and busy=0.
- REQ-032: From 0, STEP=0x80, target 0x00200, COMMIT -> cmp_out goes 0x080, 0x100, 0x180, 0x200 on successive period_ends; busy falls after the fourth move.
- REQ-033: From 0x200, STEP=0x80, target 0x150 -> cmp_out goes 0x180 then 0x150 (clamped); four period_ends produce no further change or upd_pulse.
- REQ-034: Mid-ramp at 0x100 toward 0x200, commit 0x100 -> busy=0 the next cycle with no move; commit 0x000 instead -> ramp down in steps of 0x80.
- REQ-035: COMMIT and period_end in the same cycle with STEP=0, target 0x3FFFF -> cmp_out=0x3FFFF the next cycle; read reg 5 -> 0x00.
- REQ-036: rst_n pulsed low mid-ramp at 0x180 -> cmp_out=0, busy=0, and reg 0-5 reads all return 0x00.

Source files
------------

// File: rtl/pwm_update_ctrl.sv
// PWM compare-value update controller: byte-wide staging registers, a
// commit strobe, and a per-period slew toward the committed target.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   wr_en, wr_addr, wr_data  byte write from the I2C slave
//   rd_addr, rd_data         registered read-back (1-cycle latency)
//   period_end               PWM period wrap pulse; moves happen only here
//   cmp_out                  active compare value to the PWM datapath
//   upd_pulse                high in the cycle after cmp_out changed
//   busy                     committed target not yet reached
module pwm_update_ctrl #(
   parameter int CMP_W  = 18,
   parameter int STEP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [7:0]       wr_data,
   input  logic [2:0]       rd_addr,
   output logic [7:0]       rd_data,
   input  logic             period_end,
   output logic [CMP_W-1:0] cmp_out,
   output logic             upd_pulse,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RAMP
   } state_t;

   state_t            state_q, state_d;
   logic [CMP_W-1:0]  staged_q, staged_d;
   logic [CMP_W-1:0]  target_q, target_d;
   logic [CMP_W-1:0]  cmp_q, cmp_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [7:0]        rd_q, rd_d;
   logic              upd_q, upd_d;

   logic              commit;
   logic [23:0]       stg_ext;
   logic [23:0]       rd_ext;
   logic [CMP_W-1:0]  tgt;
   logic [CMP_W:0]    diff;
   logic              down;
   logic [CMP_W-1:0]  mag;
   logic [CMP_W-1:0]  step_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         staged_q <= '0;
         target_q <= '0;
         cmp_q    <= '0;
         step_q   <= '0;
         rd_q     <= '0;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         staged_q <= staged_d;
         target_q <= target_d;
         cmp_q    <= cmp_d;
         step_q   <= step_d;
         rd_q     <= rd_d;
         upd_q    <= upd_d;
      end
   end

   always_comb begin
      staged_d = staged_q;
      step_d   = step_q;
      state_d  = state_q;
      cmp_d    = cmp_q;
      stg_ext  = 24'(staged_q);
      rd_ext   = 24'(staged_q);
      commit   = wr_en && (wr_addr == 3'd3);

      if (wr_en) begin
         case (wr_addr)
            3'd0:    stg_ext[7:0]   = wr_data;
            3'd1:    stg_ext[15:8]  = wr_data;
            3'd2:    stg_ext[23:16] = wr_data;
            3'd4:    step_d = wr_data[STEP_W-1:0];
            default: ;
         endcase
      end
      staged_d = stg_ext[CMP_W-1:0];

      // A commit redirects the move of this same cycle.
      tgt      = commit ? staged_q : target_q;
      target_d = tgt;

      // Sign taken from a one-bit-wider difference; the magnitude is
      // formed by subtracting the smaller from the larger, so no wrap.
      diff     = {1'b0, tgt} - {1'b0, cmp_q};
      down     = diff[CMP_W];
      mag      = down ? (cmp_q - tgt) : (tgt - cmp_q);
      step_ext = CMP_W'(step_q);

      if (commit && (tgt == cmp_q)) begin
         state_d = IDLE;
      end else if (commit || (state_q != IDLE)) begin
         if (period_end) begin
            if ((step_q == '0) || (mag <= step_ext)) begin
               cmp_d = tgt;
            end else if (down) begin
               cmp_d = cmp_q - step_ext;
            end else begin
               cmp_d = cmp_q + step_ext;
            end
            state_d = (cmp_d == tgt) ? IDLE : RAMP;
         end else if (commit) begin
            state_d = ARMED;
         end
      end

      upd_d = (cmp_d != cmp_q);

      case (rd_addr)
         3'd0:    rd_d = rd_ext[7:0];
         3'd1:    rd_d = rd_ext[15:8];
         3'd2:    rd_d = rd_ext[23:16];
         3'd4:    rd_d = 8'(step_q);
         3'd5:    rd_d = {6'b0, state_q == ARMED, state_q != IDLE};
         default: rd_d = 8'h00;
      endcase
   end

   assign cmp_out   = cmp_q;
   assign upd_pulse = upd_q;
   assign busy      = (state_q != IDLE);
   assign rd_data   = rd_q;

endmodule
